kitchen_responder: RTL and testbench
====================================

# kitchen_responder

Game-side responder for the kitchen command link. It decodes the 8-bit command word that the script executor drives on `in_bits` and models the player, targets and machines. It returns the 8-bit status word `out_bits` that the executor polls for its ready, has-item and wait conditions. It sits opposite the automatic script executor and is used both as a bench model and as the on-board stand-in when no host game is attached.

## Interface
- `NUM_TARGETS`, 24: number of valid target ids, 0..NUM_TARGETS-1.
- `MACHINE_BASE`, 16: ids at or above this value are machines; ids below it are item sources.
- `MOVE_LAT`, 8: cycles from an accepted move to the player arriving.
- `PROC_LAT`, 32: cycles a machine stays busy after an accepted interact.

- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_bits`  input  8  command word from the initiator.
- `out_bits`  output  8  status word, registered.
- `cur_target`  output  6  currently selected target id, registered; reset 6'h3F.

## Operation
- Command decode on `in_bits[1:0]`:
  - 01 is game control: bit2 = start, bit3 = end.
  - 11 is target select: `in_bits[7:2]` = id.
  - 10 is action: bit2 get, bit3 put, bit4 interact, bit5 move, bit6 throw. Exactly one action bit is valid; any other pattern is ignored.
  - 00 is idle.
- Edge rule: a command executes only in the cycle its value differs from the previous cycle's `in_bits`. The initiator holds commands level, so this prevents repeats. The `prev_in` register resets to 0.
- Game FSM has three states: IDLE, RUN, OVER.
  - IDLE goes to RUN on start.
  - RUN goes to OVER on end.
  - OVER exits only on `rst`.
  - Outside RUN, all non-control commands are ignored.
- Target select:
  - An id below NUM_TARGETS loads `cur_target`.
  - An out-of-range id is ignored.
- Player state: `pos` (6 bits, reset 6'h3F = nowhere), `holding` (1 bit), and `move_cnt`.
- Per-target state: `t_item[NUM_TARGETS]` and `t_busy[NUM_TARGETS]`, with matching busy counters.
  - Source targets always read `t_item` = 1 (unlimited supply).
  - Machine targets reset to 0.
- Move:
  - If `cur_target` == `pos`, there is no effect.
  - Otherwise load `move_cnt` = MOVE_LAT and set `pos` to 6'h3F.
  - On countdown reaching 0, `pos` takes `cur_target`.
  - A new move while moving restarts the count toward the new target.
- Get: requires `pos` == `cur_target`, !`holding`, `t_item`, and !`t_busy`.
  - Sets `holding`.
  - On a machine, it also clears `t_item`.
- Put: requires `pos` == `cur_target`, `holding`, a machine target, !`t_item`, and !`t_busy`.
  - Clears `holding` and sets `t_item`.
- Interact: requires `pos` == `cur_target`, a machine target, `t_item`, and !`t_busy`.
  - Sets `t_busy` for PROC_LAT cycles. `t_item` stays 1 (it becomes the processed item).
- Throw: same as put, except it requires `pos` != `cur_target` and `pos` != 6'h3F (not moving).
- A command whose precondition fails is dropped silently. It is not queued.
- Machine busy counters run independently and concurrently for all machines.

## Timing
- `out_bits` is registered, and every field reflects state after the current edge.
  - [0]: RUN.
  - [1]: OVER.
  - [2]: player ready = (`pos` == `cur_target`).
  - [3]: `holding`.
  - [4]: !`t_busy[cur_target]`.
  - [5]: `t_item[cur_target]`.
  - [7:6]: 0.
  - If `cur_target` = 6'h3F, bits [4] and [5] are 0.
- Reset values: `out_bits` = 8'h00, `cur_target` = 6'h3F. All player and target state is cleared, and the FSM is IDLE.
- Reset mid-move or mid-process aborts everything. There is no residual busy.
- Latencies, measured from the command value's first cycle on `in_bits`:
  - Action and select results are visible on `out_bits` 2 cycles later (edge detect plus state register).
  - Move arrival is at MOVE_LAT+2.
  - A machine's bit [4] returns 1 at PROC_LAT+2.
- Status that depends only on `cur_target` (bits [2], [4], [5]) updates with the same 2-cycle latency after a select.
- Simultaneity:
  - A busy counter expiring in the same cycle as a get on that machine is treated as not busy, so the get succeeds.
  - The end command wins over any in-flight move or processing; those freeze in OVER.

## Test plan
- Reset, then start (8'h05), then select 3 (8'h0F), then move (8'h22). Required response:
  - `out_bits` = 8'h01 after start.
  - Bit [2] is 0, then becomes 1 exactly MOVE_LAT+2 = 10 cycles after move.
  - Bit [5] = 1 (source).
- At source 3, get (8'h06):
  - Bit [3] goes to 1 after 2 cycles.
  - Holding get for 50 cycles produces no further change.
  - A second get after releasing to 8'h00 is dropped because `holding` is already set.
- Select 16, move, put (8'h0A), interact (8'h12):
  - Bit [3] is 0 and bit [5] is 1.
  - Bit [4] is 0 for 32 cycles, then 1.
  - Get during busy is dropped. Get afterwards sets bit [3] and clears bit [5].
- Holding an item at position 3, select 17, throw (8'h42):
  - `t_item[17]` = 1, bit [3] = 0.
  - Throw issued while moving is dropped.
- Select id 30 (8'h7B): `cur_target` is unchanged. End (8'h09): `out_bits` = 8'h02 plus frozen bits; later start and move have no effect.
- Assert `rst` for 1 cycle mid-process: the next cycle has `out_bits` = 0, `cur_target` = 6'h3F, and no busy machine.

Source files
------------

// File: rtl/kitchen_responder.sv
// Game-side responder for the kitchen command link: decodes edge-triggered command words and
// models game state, player position/holding, and per-target item/busy status.
module kitchen_responder #(
  parameter int unsigned NUM_TARGETS  = 24,
  parameter int unsigned MACHINE_BASE = 16,
  parameter int unsigned MOVE_LAT     = 8,
  parameter int unsigned PROC_LAT     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_bits,
  output logic [7:0] out_bits,
  output logic [5:0] cur_target
);

  localparam int unsigned NumMach = NUM_TARGETS - MACHINE_BASE;
  localparam int unsigned MoveW   = $clog2(MOVE_LAT + 1);
  localparam int unsigned ProcW   = $clog2(PROC_LAT + 1);

  localparam logic [5:0]       Nowhere  = 6'h3F;
  localparam logic [5:0]       MachBase = 6'(MACHINE_BASE);
  localparam logic [5:0]       NumTgt   = 6'(NUM_TARGETS);
  localparam logic [MoveW-1:0] MoveLoad = MoveW'(MOVE_LAT);
  localparam logic [ProcW-1:0] ProcLoad = ProcW'(PROC_LAT);

  typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

  state_e             state_q, state_d;
  logic [7:0]         prev_in_q, cmd_q;
  logic               cmd_vld_q;
  logic [5:0]         cur_q, cur_d, pos_q, pos_d, move_tgt_q, move_tgt_d;
  logic               holding_q, holding_d;
  logic [MoveW-1:0]   move_cnt_q, move_cnt_d;
  logic [NumMach-1:0] m_item_q, m_item_d;
  logic [ProcW-1:0]   m_cnt_q [NumMach];
  logic [ProcW-1:0]   m_cnt_d [NumMach];
  logic [7:0]         out_q, out_d;

  logic [NumMach-1:0] mach_sel;
  logic               cur_item, cur_busy, cur_is_mach, at_tgt, run, end_cmd, tick;
  logic               item_nxt, busy_nxt;

  // Status of the currently selected target. A counter at 1 expires on this edge, so it
  // already counts as idle for any command executing alongside it.
  always_comb begin
    mach_sel = '0;
    cur_item = 1'b0;
    cur_busy = 1'b0;
    for (int m = 0; m < NumMach; m++) begin
      if (cur_q == 6'(MACHINE_BASE + m)) begin
        mach_sel[m] = 1'b1;
        cur_item    = m_item_q[m];
        cur_busy    = m_cnt_q[m] > ProcW'(1);
      end
    end
    if (cur_q < MachBase) cur_item = 1'b1;
  end

  assign cur_is_mach = |mach_sel;
  assign at_tgt      = (pos_q == cur_q) && (cur_q != Nowhere);
  assign run         = (state_q == StRun);
  assign end_cmd     = cmd_vld_q && (cmd_q[1:0] == 2'b01) && cmd_q[3];
  // Timers freeze once the game ends, including on the edge the end command executes.
  assign tick        = run && !end_cmd;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pos_d      = pos_q;
    move_tgt_d = move_tgt_q;
    move_cnt_d = move_cnt_q;
    holding_d  = holding_q;
    m_item_d   = m_item_q;
    for (int m = 0; m < NumMach; m++) m_cnt_d[m] = m_cnt_q[m];

    if (tick) begin
      if (move_cnt_q == MoveW'(1)) begin
        move_cnt_d = '0;
        pos_d      = move_tgt_q;
      end else if (move_cnt_q != '0) begin
        move_cnt_d = move_cnt_q - MoveW'(1);
      end
      for (int m = 0; m < NumMach; m++) begin
        if (m_cnt_q[m] != '0) m_cnt_d[m] = m_cnt_q[m] - ProcW'(1);
      end
    end

    if (cmd_vld_q) begin
      case (cmd_q[1:0])
        2'b01: begin
          if (state_q == StIdle && cmd_q[2]) state_d = StRun;
          else if (run && cmd_q[3])          state_d = StOver;
        end
        2'b11: begin
          if (run && cmd_q[7:2] < NumTgt) cur_d = cmd_q[7:2];
        end
        2'b10: begin
          if (run) begin
            case (cmd_q[7:2])
              6'b000001: begin
                if (at_tgt && !holding_q && cur_item && !cur_busy) begin
                  holding_d = 1'b1;
                  m_item_d  = m_item_q & ~mach_sel;
                end
              end
              6'b000010: begin
                if (at_tgt && holding_q && cur_is_mach && !cur_item && !cur_busy) begin
                  holding_d = 1'b0;
                  m_item_d  = m_item_q | mach_sel;
                end
              end
              6'b000100: begin
                if (at_tgt && cur_is_mach && cur_item && !cur_busy) begin
                  for (int m = 0; m < NumMach; m++) begin
                    if (mach_sel[m]) m_cnt_d[m] = ProcLoad;
                  end
                end
              end
              6'b001000: begin
                if (cur_q != pos_q && cur_q != Nowhere) begin
                  move_cnt_d = MoveLoad;
                  move_tgt_d = cur_q;
                  pos_d      = Nowhere;
                end
              end
              6'b010000: begin
                if (pos_q != cur_q && pos_q != Nowhere && holding_q && cur_is_mach &&
                    !cur_item && !cur_busy) begin
                  holding_d = 1'b0;
                  m_item_d  = m_item_q | mach_sel;
                end
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end

    // Status word reflects post-edge state, so it is built from the next-state values.
    item_nxt = 1'b0;
    busy_nxt = 1'b0;
    for (int m = 0; m < NumMach; m++) begin
      if (cur_d == 6'(MACHINE_BASE + m)) begin
        item_nxt = m_item_d[m];
        busy_nxt = m_cnt_d[m] != '0;
      end
    end
    if (cur_d < MachBase) item_nxt = 1'b1;

    out_d    = '0;
    out_d[0] = (state_d == StRun);
    out_d[1] = (state_d == StOver);
    out_d[2] = (pos_d == cur_d) && (cur_d != Nowhere);
    out_d[3] = holding_d;
    if (cur_d != Nowhere) begin
      out_d[4] = !busy_nxt;
      out_d[5] = item_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      prev_in_q  <= '0;
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      cur_q      <= Nowhere;
      pos_q      <= Nowhere;
      move_tgt_q <= Nowhere;
      move_cnt_q <= '0;
      holding_q  <= 1'b0;
      m_item_q   <= '0;
      for (int m = 0; m < NumMach; m++) m_cnt_q[m] <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_in_q  <= in_bits;
      cmd_q      <= in_bits;
      cmd_vld_q  <= (in_bits != prev_in_q);
      cur_q      <= cur_d;
      pos_q      <= pos_d;
      move_tgt_q <= move_tgt_d;
      move_cnt_q <= move_cnt_d;
      holding_q  <= holding_d;
      m_item_q   <= m_item_d;
      for (int m = 0; m < NumMach; m++) m_cnt_q[m] <= m_cnt_d[m];
      out_q      <= out_d;
    end
  end

  assign out_bits   = out_q;
  assign cur_target = cur_q;

endmodule

// File: tb/tb_kitchen_responder.sv
// Directed bench for kitchen_responder: drives command words on the falling edge and checks the
// status word and selected target against hand-computed values.
module tb_kitchen_responder;

  logic       clk;
  logic       rst;
  logic [7:0] in_bits;
  logic [7:0] out_bits;
  logic [5:0] cur_target;

  int checks   = 0;
  int failures = 0;

  kitchen_responder dut (
    .clk        (clk),
    .rst        (rst),
    .in_bits    (in_bits),
    .out_bits   (out_bits),
    .cur_target (cur_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Apply a command word, then wait n falling edges.
  task automatic drive(input logic [7:0] v, input int n);
    in_bits = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    in_bits = 8'h00;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out", out_bits, 8'h00);
    chk("reset_cur", {2'b00, cur_target}, 8'h3F);

    // Start, select source 3, move there.
    drive(8'h05, 2);  chk("start", out_bits, 8'h01);
    drive(8'h0F, 2);  chk("sel3_cur", {2'b00, cur_target}, 8'h03);
    chk("sel3_out", out_bits, 8'h31);
    drive(8'h22, 9);  chk("move_not_yet", out_bits, 8'h31);
    drive(8'h22, 1);  chk("move_arrive", out_bits, 8'h35);

    // Get at source, held level, then a repeat get while already holding.
    drive(8'h06, 2);  chk("get_src", out_bits, 8'h3D);
    drive(8'h06, 50); chk("get_held", out_bits, 8'h3D);
    drive(8'h00, 2);
    drive(8'h06, 2);  chk("get_again", out_bits, 8'h3D);

    // Machine 16: move, put, interact, get during and after busy.
    drive(8'h43, 2);  chk("sel16", out_bits, 8'h19);
    drive(8'h22, 10); chk("move16", out_bits, 8'h1D);
    drive(8'h0A, 2);  chk("put16", out_bits, 8'h35);
    drive(8'h12, 2);  chk("interact16", out_bits, 8'h25);
    drive(8'h06, 31); chk("busy_get_drop", out_bits, 8'h25);
    drive(8'h06, 1);  chk("busy_done", out_bits, 8'h35);
    drive(8'h00, 1);
    drive(8'h06, 2);  chk("get16", out_bits, 8'h1D);

    // Back to 3, throw at machine 17.
    drive(8'h0F, 2);  chk("sel3_hold", out_bits, 8'h39);
    drive(8'h22, 10); chk("move3", out_bits, 8'h3D);
    drive(8'h47, 2);  chk("sel17", out_bits, 8'h19);
    drive(8'h42, 2);  chk("throw17", out_bits, 8'h31);

    // Throw while moving is dropped.
    drive(8'h0F, 2);  chk("sel3_b", out_bits, 8'h35);
    drive(8'h06, 2);  chk("get3_b", out_bits, 8'h3D);
    drive(8'h4B, 2);  chk("sel18", out_bits, 8'h19);
    drive(8'h22, 2);  chk("moving18", out_bits, 8'h19);
    drive(8'h42, 2);  chk("throw_moving", out_bits, 8'h19);
    drive(8'h00, 6);  chk("arrive18", out_bits, 8'h1D);

    // Out-of-range select, then end with a machine mid-process.
    drive(8'h7B, 2);  chk("sel30_cur", {2'b00, cur_target}, 8'h12);
    chk("sel30_out", out_bits, 8'h1D);
    drive(8'h0A, 2);  chk("put18", out_bits, 8'h35);
    drive(8'h12, 2);  chk("interact18", out_bits, 8'h25);
    drive(8'h09, 2);  chk("end", out_bits, 8'h26);
    drive(8'h09, 40); chk("frozen", out_bits, 8'h26);
    drive(8'h05, 2);  chk("over_start", out_bits, 8'h26);
    drive(8'h0F, 2);  chk("over_sel", {2'b00, cur_target}, 8'h12);
    chk("over_out", out_bits, 8'h26);

    // Reset with a machine frozen busy.
    in_bits = 8'h00;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_out", out_bits, 8'h00);
    chk("rst2_cur", {2'b00, cur_target}, 8'h3F);
    drive(8'h05, 2);  chk("rst2_start", out_bits, 8'h01);
    drive(8'h4B, 2);  chk("rst2_sel18", out_bits, 8'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
